uart_tx_fifo: RTL and testbench

- Byte-stream UART transmitter that consumes the tester's status text and drives the board `txp` pin.
- Sits directly downstream of the DDR test controller's print logic. It accepts ASCII bytes over a valid/ready handshake into a small FIFO.
- Serialises each byte as 8N1 at a fixed baud rate, so the message source never stalls on bit timing.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_byte_fifo.sv | 69 ++++++
 rtl/uart_tx_fifo.sv | 157 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmitter.
// Optional even-parity frame (8E1) is selected by UART_TX_PARITY_EN.
package uart_pkg;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;
`endif

  // Rounded clock cycles per bit period.
  function automatic int calc_bit_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with registered level/full/empty and same-cycle read and write.
// DEPTH must be a power of two and at least 2.
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          wr_en_i,
  input  logic [7:0]    wr_data_i,
  input  logic          rd_en_i,
  output logic [7:0]    rd_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("uart_byte_fifo: DEPTH must be a power of two >= 2");
  end

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic        full_q, full_d;
  logic        empty_q, empty_d;
  logic        wr_fire, rd_fire;

  assign wr_fire = wr_en_i && !full_q;
  assign rd_fire = rd_en_i && !empty_q;

  // Pointers carry one extra wrap bit, so their difference is the occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW + 1)'(wr_fire);
    rd_ptr_d = rd_ptr_q + (AW + 1)'(rd_fire);
    level_d  = wr_ptr_d - rd_ptr_d;
    full_d   = (level_d == (AW + 1)'(DEPTH));
    empty_d  = (level_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_fire) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o    = full_q;
  assign empty_o   = empty_q;
  assign level_o   = level_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter, 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low)
// DATA   | 8 data bits, LSB first
// PARITY | even parity bit (parity builds only)
// STOP   | stop bit (high); pops the next byte with no idle gap
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 27_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          txp,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BIT_DIV = calc_bit_div(CLK_FREQ, BAUD);
  localparam int DIV_W   = $clog2(BIT_DIV);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(BIT_DIV - 1);

  if (BIT_DIV < 4) begin : g_bad_div
    $error("uart_tx_fifo: BIT_DIV must be at least 4");
  end

  tx_state_e        state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             txp_q, txp_d;
  logic             busy_q, busy_d;
  logic             pop, tick;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_rd_data;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .wr_en_i   (in_valid),
    .wr_data_i (in_data),
    .rd_en_i   (pop),
    .rd_data_o (fifo_rd_data),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level)
  );

  assign tick = (div_q == DIV_TC);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    if (state_q != ST_IDLE) div_d = tick ? '0 : div_q + DIV_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          div_d   = '0;
          bit_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: if (tick) state_d = ST_DATA;
      ST_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
`ifdef UART_TX_PARITY_EN
          if (bit_q == 3'd7) state_d = ST_PARITY;
`else
          if (bit_q == 3'd7) state_d = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (tick) state_d = ST_STOP;
`endif
      ST_STOP: begin
        if (tick) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rd_data;
            bit_d   = '0;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later (registered output).
  always_comb begin
    txp_d = LINE_IDLE;
    case (state_q)
      ST_START:  txp_d = LINE_START;
      ST_DATA:   txp_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txp_d = parity_q;
`endif
      ST_STOP:   txp_d = LINE_STOP;
      default:   txp_d = LINE_IDLE;
    endcase
    busy_d = !fifo_empty || (state_q != ST_IDLE);
  end

`ifdef UART_TX_PARITY_EN
  always_comb begin
    parity_d = parity_q;
    if (pop) parity_d = ^fifo_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_q <= 1'b0;
    else        parity_q <= parity_d;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txp_q   <= LINE_IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txp_q   <= txp_d;
      busy_q  <= busy_d;
    end
  end

  assign in_ready = !fifo_full;
  assign txp      = txp_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a fast instance (BIT_DIV=10, depth 4) and a default-rate instance.
// Honours UART_TX_PARITY_EN for the expected frame shape.
`define CHECK(TAG, OBS, EXP) \
  begin \
    n_chk++; \
    assert ((OBS) === (EXP)) else begin \
      n_fail++; \
      $error("FAIL %s: observed %0h expected %0h", TAG, (OBS), (EXP)); \
    end \
  end

module tb_uart_tx_fifo;

  localparam int BD_A = 10;
  localparam int BD_B = 234;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] a_data = '0, b_data = '0;
  logic       a_valid = 1'b0, b_valid = 1'b0;
  logic       a_ready, a_txp, a_busy, b_ready, b_txp, b_busy;
  logic [2:0] a_level;
  logic [4:0] b_level;

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  int a_bad = 0, b_bad = 0;
  logic [7:0] a_rx[$], b_rx[$], a_exp[$], mdl_q[$];
  int b_starts[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_fifo #(.CLK_FREQ(10), .BAUD(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .txp(a_txp), .busy(a_busy), .fifo_level(a_level)
  );

  uart_tx_fifo dut_b (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .txp(b_txp), .busy(b_busy), .fifo_level(b_level)
  );

  // Line receiver: mid-bit sampling on the falling clock edge.
  task automatic rx_frame(input bit sel, input int bd);
    logic [7:0] d;
    int t0;
    @(negedge clk);
    while ((sel ? b_txp : a_txp) !== 1'b0) @(negedge clk);
    t0 = cyc;
    repeat (bd / 2) @(negedge clk);
    if ((sel ? b_txp : a_txp) !== 1'b0) begin
      if (sel) b_bad++; else a_bad++;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      repeat (bd) @(negedge clk);
      d[i] = sel ? b_txp : a_txp;
    end
`ifdef UART_TX_PARITY_EN
    repeat (bd) @(negedge clk);
    if ((sel ? b_txp : a_txp) !== ^d) begin
      if (sel) b_bad++; else a_bad++;
    end
`endif
    repeat (bd) @(negedge clk);
    if ((sel ? b_txp : a_txp) !== 1'b1) begin
      if (sel) b_bad++; else a_bad++;
    end
    if (sel) begin
      b_rx.push_back(d);
      b_starts.push_back(t0);
    end else begin
      a_rx.push_back(d);
    end
  endtask

  initial forever rx_frame(1'b0, BD_A);
  initial forever rx_frame(1'b1, BD_B);

  // Expected line k edges after the first write, frames of mdl_q sent back to back.
  function automatic logic line_model(input int k, input int bd);
    int j, f, t;
    logic [7:0] b;
    if (k < 2) return 1'b1;
    j = k - 2;
    f = j / (NB * bd);
    if (f >= mdl_q.size()) return 1'b1;
    t = (j % (NB * bd)) / bd;
    b = mdl_q[f];
    if (t == 0) return 1'b0;
    if (t <= 8) return b[t-1];
    if (NB == 11 && t == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic push(input bit sel, input logic [7:0] b, output int edge_n);
    bit acc;
    int guard = 0;
    if (sel) begin b_valid = 1'b1; b_data = b; end
    else     begin a_valid = 1'b1; a_data = b; end
    do begin
      acc = sel ? b_ready : a_ready;
      @(posedge clk); #1;
      guard++;
    end while (!acc && guard < 5000);
    edge_n = cyc;
    `CHECK("push_accepted", acc, 1'b1)
    if (sel) b_valid = 1'b0; else a_valid = 1'b0;
  endtask

  task automatic wait_idle_a(input int bound);
    int g = 0;
    while (a_busy && g < bound) begin @(posedge clk); #1; g++; end
    `CHECK("a_idle_timeout", a_busy, 1'b0)
    repeat (BD_A) begin @(posedge clk); #1; end
  endtask

  task automatic check_rx_a();
    `CHECK("a_rx_count", a_rx.size(), a_exp.size())
    for (int i = 0; i < a_exp.size() && i < a_rx.size(); i++)
      `CHECK("a_rx_byte", a_rx[i], a_exp[i])
    a_rx.delete();
    a_exp.delete();
  endtask

  task automatic wave_test(input logic [7:0] b0, input logic [7:0] b1, input bit two);
    int n, m, k, kmax;
    mdl_q.delete();
    mdl_q.push_back(b0);
    a_exp.push_back(b0);
    push(1'b0, b0, n);
    if (two) begin
      mdl_q.push_back(b1);
      a_exp.push_back(b1);
      push(1'b0, b1, m);
    end
    kmax = 2 + mdl_q.size() * NB * BD_A + 3;
    while (cyc - n < kmax) begin
      @(posedge clk); #1;
      k = cyc - n;
      `CHECK("txp_wave", a_txp, line_model(k, BD_A))
      `CHECK("busy_wave", a_busy, (k >= 1 && k < 2 + mdl_q.size() * NB * BD_A))
    end
  endtask

  initial begin
    int n, g, lows, busys;
    logic prev_ready;
    logic [7:0] r;
    string s;

    @(posedge clk); #1;
    `CHECK("rst_txp", a_txp, 1'b1)
    `CHECK("rst_ready", a_ready, 1'b1)
    `CHECK("rst_busy", a_busy, 1'b0)
    `CHECK("rst_level", a_level, 3'd0)
    `CHECK("rst_b_txp", b_txp, 1'b1)
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    wave_test(8'h55, 8'h00, 1'b0);
    wave_test(8'h41, 8'h0A, 1'b1);
    wave_test(8'h07, 8'h03, 1'b1);
    wait_idle_a(100);
    check_rx_a();

    // Backpressure: one byte in flight, then fill the 4-entry FIFO and hold a fifth.
    push(1'b0, 8'h10, n); a_exp.push_back(8'h10);
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < 4; i++) begin
      r = 8'(8'hA0 + i);
      push(1'b0, r, n);
      a_exp.push_back(r);
    end
    `CHECK("full_level", a_level, 3'd4)
    `CHECK("full_ready", a_ready, 1'b0)
    a_valid = 1'b1; a_data = 8'h5E; a_exp.push_back(8'h5E);
    g = 0;
    prev_ready = a_ready;
    while (a_level == 3'd4 && g < 300) begin
      prev_ready = a_ready;
      @(posedge clk); #1; g++;
    end
    `CHECK("ready_in_pop_cycle", prev_ready, 1'b0)
    `CHECK("level_after_pop", a_level, 3'd3)
    `CHECK("ready_after_pop", a_ready, 1'b1)
    @(posedge clk); #1;
    `CHECK("fifth_accepted", a_level, 3'd4)
    a_valid = 1'b0;
    wait_idle_a(6 * NB * BD_A + 50);
    check_rx_a();

    // Random bytes with random gaps.
    for (int i = 0; i < 12; i++) begin
      r = 8'($urandom);
      a_exp.push_back(r);
      push(1'b0, r, n);
      repeat ($urandom_range(0, 30)) begin @(posedge clk); #1; end
    end
    wait_idle_a(12 * NB * BD_A + 100);
    check_rx_a();
    `CHECK("a_frame_errors", a_bad, 0)

    // Reset 35 cycles into a 0xFF frame with three bytes queued.
    push(1'b0, 8'hFF, n);
    push(1'b0, 8'h11, g);
    push(1'b0, 8'h22, g);
    push(1'b0, 8'h33, g);
    `CHECK("queued_level", a_level, 3'd3)
    while (cyc < n + 37) begin @(posedge clk); #1; end
    #3 rst_n = 1'b0;
    #1;
    `CHECK("async_rst_txp", a_txp, 1'b1)
    `CHECK("async_rst_level", a_level, 3'd0)
    `CHECK("async_rst_busy", a_busy, 1'b0)
    `CHECK("async_rst_ready", a_ready, 1'b1)
    @(posedge clk); #1;
    rst_n = 1'b1;
    lows = 0; busys = 0;
    repeat (300) begin
      @(posedge clk); #1;
      if (a_txp !== 1'b1) lows++;
      if (a_busy !== 1'b0) busys++;
    end
    `CHECK("post_rst_line_low", lows, 0)
    `CHECK("post_rst_busy", busys, 0)
    a_rx.delete();

    // Default rate: status string, contiguous frames.
    s = "Init Complete\n";
    push(1'b1, s[0], n);
    for (int i = 1; i < s.len(); i++) push(1'b1, s[i], g);
    g = 0;
    while (b_busy && g < 14 * NB * BD_B + 500) begin @(posedge clk); #1; g++; end
    `CHECK("b_idle_timeout", b_busy, 1'b0)
    repeat (10) begin @(posedge clk); #1; end
    `CHECK("b_rx_count", b_rx.size(), s.len())
    for (int i = 0; i < s.len() && i < b_rx.size(); i++)
      `CHECK("b_rx_char", b_rx[i], 8'(s[i]))
    if (b_starts.size() > 0) `CHECK("b_first_latency", b_starts[0] - n, 2)
    for (int i = 1; i < b_starts.size(); i++)
      `CHECK("b_frame_period", b_starts[i] - b_starts[i-1], NB * BD_B)
    `CHECK("b_frame_errors", b_bad, 0)

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
